// File: rtl/div_unit_pkg.sv
// Shared definitions for the DIV/DIVU execute-stage divider: FSM encoding,
// default iteration count and the decoder funct codes that launch it.
package div_unit_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DBZ  = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } div_state_e;

  localparam int DIV_CYCLES_DEF = 32;

  // Same values as the main decoder's DIV/DIVU funct field.
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;
endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake. master = EX/hazard side, slave = div_unit.
interface div_unit_if;
  logic        start;
  logic        is_signed;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  logic        stall;

  modport master (output start, is_signed, annul, a, b,
                  input  result, ready, busy, stall);
  modport slave  (input  start, is_signed, annul, a, b,
                  output result, ready, busy, stall);
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. result = {remainder, quotient} -> {HI, LO}.
// One quotient bit per cycle on magnitudes, sign fix-up folded into the final load.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  dif
);
  localparam int CW = $clog2(DIV_CYCLES);

  div_state_e    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   dvd_q;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [31:0]   dvs;
  logic [31:0]   rem;
  logic [31:0]   a_raw;
  logic          neg_a, neg_b;
  logic [63:0]   result_q;
  logic          busy_q;
  logic          ready;
  logic          accept, last;
  logic [32:0]   shifted, diff;
  logic [31:0]   q_nxt, r_nxt;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // 0x80000000 maps onto itself, which as unsigned is the right magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
    return (sgn & x[31]) ? neg32(x) : x;
  endfunction

  assign accept  = dif.start & ~dif.annul;
  assign last    = (state == S_ON) && (cnt == CW'(DIV_CYCLES - 1));

  assign shifted = {rem, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_nxt   = {dvd_q[30:0], ~diff[32]};
  assign r_nxt   = diff[32] ? shifted[31:0] : diff[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == S_ON) || (state_nxt == S_DBZ);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (dif.b == 32'd0) ? S_DBZ : S_ON;
      S_ON:    if (dif.annul) state_nxt = S_IDLE;
               else if (last) state_nxt = S_END;
      S_DBZ:   state_nxt = dif.annul ? S_IDLE : S_END;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == S_END) & ~dif.annul;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dvd_q    <= '0;
      dvs      <= '0;
      rem      <= '0;
      a_raw    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          dvd_q <= abs32(dif.a, dif.is_signed);
          dvs   <= abs32(dif.b, dif.is_signed);
          rem   <= '0;
          cnt   <= '0;
          a_raw <= dif.a;
          neg_a <= dif.is_signed & dif.a[31];
          neg_b <= dif.is_signed & dif.b[31];
        end
        S_ON: begin
          dvd_q <= q_nxt;
          rem   <= r_nxt;
          cnt   <= cnt + 1'b1;
          if (last && !dif.annul)
            result_q <= {neg_a ? neg32(r_nxt) : r_nxt,
                         (neg_a ^ neg_b) ? neg32(q_nxt) : q_nxt};
        end
        S_DBZ: if (!dif.annul) result_q <= {a_raw, 32'hFFFF_FFFF};
        default: ;
      endcase
    end
  end

  assign dif.result = result_q;
  assign dif.ready  = ready;
  assign dif.busy   = busy_q;
  assign dif.stall  = dif.start & ~ready;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// against an integer-arithmetic model of DIV/DIVU.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_last = '0;

  div_unit_if dif();
  div_unit dut (.clk(clk), .rst(rst), .dif(dif));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    int sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!s) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sx = x; sy = y;
    q = sx / sy; r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Waits one cycle so the FSM is idle, then holds start until ready.
  task automatic do_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] res, output int lat);
    @(posedge clk); #1;
    dif.is_signed = s; dif.a = x; dif.b = y; dif.start = 1'b1;
    lat = -1; res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (dif.ready) begin lat = k; res = dif.result; break; end
    end
    dif.start = 1'b0;
  endtask

  task automatic test_reset;
    dif.start = 1'b0; dif.is_signed = 1'b0; dif.annul = 1'b0; dif.a = '0; dif.b = '0;
    #12;
    checks++; if (dif.result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", dif.result); end
    checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dif.ready); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dif.busy); end
    dif.start = 1'b1; #1;
    checks++; if (dif.stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", dif.stall); end
    dif.start = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_divu_basic;
    int lat = -1, stall_cnt = 0;
    @(posedge clk); #1;
    dif.is_signed = 1'b0; dif.a = 32'd100; dif.b = 32'd7; dif.start = 1'b1;
    #1; if (dif.stall) stall_cnt++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++; if (dif.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", dif.busy); end
      end
      if (dif.ready) begin
        lat = k;
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("FAIL basic_stall_at_ready got %b want 0", dif.stall); end
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_ready got %b want 0", dif.busy); end
        checks++; if (dif.result !== {32'd2, 32'd14}) begin errors++; $display("FAIL basic_result got %h want %h", dif.result, {32'd2, 32'd14}); end
        break;
      end
      if (dif.stall) stall_cnt++;
    end
    dif.start = 1'b0;
    exp_last = {32'd2, 32'd14};
    checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
    checks++; if (stall_cnt !== 33) begin errors++; $display("FAIL basic_stall_cycles got %0d want 33", stall_cnt); end
  endtask

  task automatic test_signed_cases;
    logic [31:0] xs [6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'h1234, 32'hFFFF_FFF0};
    logic [31:0] ys [6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic        ss [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] want [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                              {32'd0, 32'h8000_0000}, {32'h8000_0000, 32'd0},
                              {32'h1234, 32'hFFFF_FFFF}, {32'hFFFF_FFF0, 32'hFFFF_FFFF}};
    logic [63:0] res; int lat;
    for (int i = 0; i < 6; i++) begin
      do_div(ss[i], xs[i], ys[i], res, lat);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL corner%0d_result got %h want %h", i, res, want[i]); end
      checks++; if (lat !== ((ys[i] == 0) ? 2 : 33)) begin errors++; $display("FAIL corner%0d_latency got %0d want %0d", i, lat, (ys[i] == 0) ? 2 : 33); end
      exp_last = want[i];
    end
  endtask

  task automatic test_annul;
    int pulses = 0; logic [63:0] res; int lat;
    @(posedge clk); #1;
    dif.is_signed = 1'b0; dif.a = 32'd1000; dif.b = 32'd3; dif.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; if (dif.ready) pulses++; end
    dif.annul = 1'b1;
    @(posedge clk); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL annul_busy got %b want 0", dif.busy); end
    dif.start = 1'b0; dif.annul = 1'b0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (dif.ready) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL annul_ready_pulses got %0d want 0", pulses); end
    checks++; if (dif.result !== exp_last) begin errors++; $display("FAIL annul_result_held got %h want %h", dif.result, exp_last); end
    do_div(1'b0, 32'd9, 32'd3, res, lat);
    checks++; if (res !== {32'd0, 32'd3}) begin errors++; $display("FAIL annul_then_divu got %h want %h", res, {32'd0, 32'd3}); end
    exp_last = {32'd0, 32'd3};
  endtask

  task automatic test_rst_mid;
    int lat = -1;
    @(posedge clk); #1;
    dif.is_signed = 1'b0; dif.a = 32'd500; dif.b = 32'd5; dif.start = 1'b1;
    for (int k = 1; k <= 15; k++) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    checks++; if (dif.result !== 64'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", dif.result); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", dif.busy); end
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (dif.ready) begin lat = k; break; end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL rstmid_latency got %0d want 33", lat); end
    checks++; if (dif.result !== {32'd0, 32'd100}) begin errors++; $display("FAIL rstmid_result2 got %h want %h", dif.result, {32'd0, 32'd100}); end
    dif.start = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat1 = -1, lat2 = -1;
    @(posedge clk); #1;
    dif.is_signed = 1'b1; dif.a = 32'hFFFF_FF9C; dif.b = 32'd9; dif.start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (lat1 < 0 && dif.ready) begin
        lat1 = k;
        checks++; if (dif.result !== ref_div(1'b1, 32'hFFFF_FF9C, 32'd9)) begin errors++; $display("FAIL b2b_first got %h want %h", dif.result, ref_div(1'b1, 32'hFFFF_FF9C, 32'd9)); end
        dif.is_signed = 1'b0; dif.a = 32'hDEAD_BEEF; dif.b = 32'd1000;
      end else if (lat1 > 0 && k == lat1 + 1) begin
        checks++; if (dif.ready !== 1'b0 || dif.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%b busy=%b want 0/0", dif.ready, dif.busy); end
      end else if (lat1 > 0 && dif.ready) begin
        lat2 = k;
        checks++; if (dif.result !== ref_div(1'b0, 32'hDEAD_BEEF, 32'd1000)) begin errors++; $display("FAIL b2b_second got %h want %h", dif.result, ref_div(1'b0, 32'hDEAD_BEEF, 32'd1000)); end
        break;
      end
    end
    dif.start = 1'b0;
    checks++; if (lat1 !== 33 || lat2 !== 67) begin errors++; $display("FAIL b2b_latency got %0d/%0d want 33/67", lat1, lat2); end
  endtask

  task automatic test_random;
    logic [63:0] res; int lat; logic s; logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = $urandom_range(1, 15);
        3: y = -$urandom_range(1, 15);
        default: y = $urandom;
      endcase
      do_div(s, x, y, res, lat);
      checks++; if (res !== ref_div(s, x, y)) begin errors++; $display("FAIL rand%0d s=%b a=%h b=%h got %h want %h", i, s, x, y, res, ref_div(s, x, y)); end
      checks++; if (lat !== ((y == 0) ? 2 : 33)) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, (y == 0) ? 2 : 33); end
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed_cases;
    test_annul;
    test_rst_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
